tri_bus_arbiter_k: RTL

- Round-robin arbiter that shares one tri-state bus between NUM_REQ drivers.
- Each driver is a tri_state_k bank gated by an active-low output enable.
- The block issues one-hot-cold oe_ vectors: at most one driver is enabled at a time.
- Every ownership change passes through an enforced all-off turnaround, so drivers can never contend on the bus.

---
 rtl/tri_bus_pkg_k.sv | 19 +
 rtl/rr_pick_k.sv | 30 +++
 rtl/tri_bus_arbiter_k.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tri_bus_pkg_k.sv
// Shared types and constants for the tri-state bus arbiter family.
// Holds the arbiter state encoding, the grant-index width helper and the default timing constants.
package tri_bus_pkg_k;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    localparam int TURN_CYCLES_DEF = 1;
    localparam int HOLD_MAX_DEF    = 8;

    // The width never drops to zero, so a two-driver bus still has a 1-bit index.
    function automatic int id_w_f(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick_k.sv
// Combinational round-robin priority encoder. The search starts one past last_i and wraps around.
// Shared with other bus masters.
module rr_pick_k
    import tri_bus_pkg_k::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_w_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);

    // Scan from the lowest priority to the highest. The last hit is then the closest requester after last_i.
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        any_o    = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                winner_o = ID_W'(idx);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter_k.sv
// Round-robin owner of a shared tri-state bus. At most one active-low oe_ is asserted, with an all-off turnaround on every handover.
// Define ARB_TIMEOUT_EN to revoke any grant held for HOLD_MAX cycles.
//
// state | meaning
// IDLE  | bus released, waiting for any request
// GRANT | one driver owns the bus (oe_[gnt_id] low)
// TURN  | all oe_ high for TURN_CYCLES before the next owner
module tri_bus_arbiter_k
    import tri_bus_pkg_k::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TURN_CYCLES = TURN_CYCLES_DEF,
    parameter int HOLD_MAX    = HOLD_MAX_DEF,
    parameter int ID_W        = id_w_f(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] oe_,
    output logic [ID_W-1:0]    gnt_id,
    output logic               bus_busy,
    output logic               timeout
);

    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    if (NUM_REQ < 2)     begin : g_chk_num_req  $error("NUM_REQ must be at least 2");     end
    if (TURN_CYCLES < 1) begin : g_chk_turn     $error("TURN_CYCLES must be at least 1"); end
    if (HOLD_MAX < 1)    begin : g_chk_hold     $error("HOLD_MAX must be at least 1");    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] oe_q, oe_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic               busy_q, busy_d;
    logic [TW-1:0]      turn_q, turn_d;
    logic [ID_W-1:0]    win;
    logic               any_req;
    logic               do_grant, rel_bus;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX) + 1;
    logic [HW-1:0] hold_q, hold_d;
    logic          to_q, to_d;
`endif

    rr_pick_k #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_i    (req),
        .last_i   (last_q),
        .winner_o (win),
        .any_o    (any_req)
    );

    always_comb begin
        state_d  = state_q;
        oe_d     = oe_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        busy_d   = busy_q;
        turn_d   = turn_q;
        do_grant = 1'b0;
        rel_bus  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d   = hold_q;
        to_d     = 1'b0;
`endif
        case (state_q)
            IDLE: do_grant = any_req;
            GRANT: begin
                if (!req[gnt_q]) begin
                    rel_bus = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if (hold_q == HW'(HOLD_MAX - 1)) begin
                    rel_bus = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
`endif
                end
            end
            TURN: begin
                // Turnaround is a down-counter; terminal count is the final all-off cycle.
                if (turn_q == '0) begin
                    if (any_req) do_grant = 1'b1;
                    else         state_d  = IDLE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel_bus) begin
            oe_d    = '1;
            busy_d  = 1'b0;
            last_d  = gnt_q;
            state_d = TURN;
            turn_d  = TW'(TURN_CYCLES - 1);
        end
        if (do_grant) begin
            oe_d      = '1;
            oe_d[win] = 1'b0;
            gnt_d     = win;
            busy_d    = 1'b1;
            state_d   = GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            oe_q    <= '1;
            gnt_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            oe_q    <= oe_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            turn_q  <= turn_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            to_q   <= to_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    assign oe_      = oe_q;
    assign gnt_id   = gnt_q;
    assign bus_busy = busy_q;

endmodule
